// File: rtl/ula_wb_stage_if.sv
// rtl/ula_wb_stage_if.sv - ALU-result and register-file write handshake bundle for ula_wb_stage
//
// Purpose: carries the two valid/ready streams of the writeback stage.
//   in_*  : ALU result stream (producer = ALU, consumer = stage)
//   wb_*  : register-file write stream (producer = stage, consumer = register file)
// Modports:
//   master : environment view (drives in_*, wb_ready; observes in_ready, wb_*)
//   slave  : stage view (consumes in_*, wb_ready; drives in_ready, wb_*)
interface ula_wb_stage_if #(
    parameter int DATA_WIDTH     = 16,
    parameter int OPCODE_WIDTH   = 4,
    parameter int REG_ADDR_WIDTH = 4
);
    logic                      in_valid;
    logic                      in_ready;
    logic [OPCODE_WIDTH-1:0]   in_opcode;
    logic [REG_ADDR_WIDTH-1:0] in_rd;
    logic [DATA_WIDTH-1:0]     in_data;
    logic [4:0]                in_rflags;

    logic                      wb_valid;
    logic                      wb_ready;
    logic [REG_ADDR_WIDTH-1:0] wb_rd;
    logic [DATA_WIDTH-1:0]     wb_data;

    modport master (
        output in_valid, in_opcode, in_rd, in_data, in_rflags, wb_ready,
        input  in_ready, wb_valid, wb_rd, wb_data
    );

    modport slave (
        input  in_valid, in_opcode, in_rd, in_data, in_rflags, wb_ready,
        output in_ready, wb_valid, wb_rd, wb_data
    );
endinterface

// File: rtl/ula_wb_stage.sv
// rtl/ula_wb_stage.sv - execute-to-writeback stage: flag register, 2-entry write skid FIFO, div-by-zero trap
//
// Optional feature macro: ULA_WB_STICKY_OVF_EN (flags_q[4] overflow bit becomes sticky)
//
// Ports:
//   i_clk            clock, all state on rising edge
//   i_rst            synchronous reset, active-high
//   bus (slave)      in_* ALU result stream, wb_* register-file write stream
//   i_flags_clr      clear flag register (an accept on the same edge wins)
//   o_flags_q        processor flag register {ovf, gt, eq, lt, dz}
//   o_div_zero_trap  one-cycle pulse after a divide-by-zero is accepted
//   o_wb_count       number of completed register writes (wraps)
module ula_wb_stage #(
    parameter int DATA_WIDTH     = 16,
    parameter int OPCODE_WIDTH   = 4,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    ula_wb_stage_if.slave        bus,
    input  logic                 i_flags_clr,
    output logic [4:0]           o_flags_q,
    output logic                 o_div_zero_trap,
    output logic [CNT_WIDTH-1:0] o_wb_count
);
    // Opcode encodings shared with the ALU.
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OP_CMP = OPCODE_WIDTH'(2);
    localparam logic [OPCODE_WIDTH-1:0] OP_MUL = OPCODE_WIDTH'(3);
    localparam logic [OPCODE_WIDTH-1:0] OP_DIV = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0] OP_AND = OPCODE_WIDTH'(5);
    localparam logic [OPCODE_WIDTH-1:0] OP_OR  = OPCODE_WIDTH'(6);
    localparam logic [OPCODE_WIDTH-1:0] OP_NOT = OPCODE_WIDTH'(7);

    // FIFO storage: entry 0 is the head driven onto wb_*, entry 1 the tail.
    logic [1:0]                r_count;
    logic [REG_ADDR_WIDTH-1:0] r_head_rd;
    logic [DATA_WIDTH-1:0]     r_head_data;
    logic [REG_ADDR_WIDTH-1:0] r_tail_rd;
    logic [DATA_WIDTH-1:0]     r_tail_data;
    logic [4:0]                r_flags;
    logic                      r_trap;
    logic [CNT_WIDTH-1:0]      r_wb_count;

    logic       w_accept;
    logic       w_known;
    logic       w_enq;
    logic       w_dz;
    logic       w_push;
    logic       w_pop;
    logic [4:0] w_acc_flags;

    // in_ready depends only on registered occupancy so there is no
    // combinational path from wb_ready back to the ALU.
    assign bus.in_ready = !i_rst && (r_count != 2'd2);
    assign bus.wb_valid = (r_count != 2'd0);
    assign bus.wb_rd    = r_head_rd;
    assign bus.wb_data  = r_head_data;

    assign o_flags_q       = r_flags;
    assign o_div_zero_trap = r_trap;
    assign o_wb_count      = r_wb_count;

    assign w_accept = bus.in_valid && bus.in_ready;
    assign w_pop    = bus.wb_valid && bus.wb_ready;
    assign w_push   = w_accept && w_enq;

    always_comb begin
        w_known = 1'b0;
        w_enq   = 1'b0;
        w_dz    = 1'b0;
        case (bus.in_opcode)
            OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_NOT: begin
                w_known = 1'b1;
                w_enq   = 1'b1;
            end
            OP_DIV: begin
                w_known = 1'b1;
                w_enq   = !bus.in_rflags[0];
                w_dz    = bus.in_rflags[0];
            end
            OP_CMP: begin
                w_known = 1'b1;
            end
            default: begin
                w_known = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_acc_flags = bus.in_rflags;
`ifdef ULA_WB_STICKY_OVF_EN
        // Overflow accumulates until explicitly cleared; a clear on the
        // same edge restarts accumulation from the incoming bit.
        w_acc_flags[4] = i_flags_clr ? bus.in_rflags[4] : (r_flags[4] | bus.in_rflags[4]);
`else
        w_acc_flags[4] = bus.in_rflags[4];
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count     <= 2'd0;
            r_head_rd   <= '0;
            r_head_data <= '0;
            r_tail_rd   <= '0;
            r_tail_data <= '0;
            r_flags     <= 5'd0;
            r_trap      <= 1'b0;
            r_wb_count  <= '0;
        end else begin
            r_trap <= w_accept && w_dz;

            if (w_accept && w_known) begin
                r_flags <= w_acc_flags;
            end else if (i_flags_clr) begin
                r_flags <= 5'd0;
            end

            if (w_pop) begin
                r_wb_count <= r_wb_count + CNT_WIDTH'(1);
            end

            if (w_push && w_pop) begin
                // Only reachable with one entry: the new result becomes the head.
                r_head_rd   <= bus.in_rd;
                r_head_data <= bus.in_data;
            end else if (w_push) begin
                if (r_count == 2'd0) begin
                    r_head_rd   <= bus.in_rd;
                    r_head_data <= bus.in_data;
                end else begin
                    r_tail_rd   <= bus.in_rd;
                    r_tail_data <= bus.in_data;
                end
                r_count <= r_count + 2'd1;
            end else if (w_pop) begin
                if (r_count == 2'd2) begin
                    r_head_rd   <= r_tail_rd;
                    r_head_data <= r_tail_data;
                end
                r_count <= r_count - 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_ula_wb_stage.sv
// tb/tb_ula_wb_stage.sv - directed self-checking bench for ula_wb_stage
module tb_ula_wb_stage;
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_CMP = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd4;
    localparam logic [3:0] OP_BAD = 4'd15;

    logic        clk;
    logic        rst;
    logic        flags_clr;
    logic [4:0]  flags_q;
    logic        trap;
    logic [15:0] wb_count;

    int checks;
    int errors;
    int exp_count;

    ula_wb_stage_if bus ();

    ula_wb_stage dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .bus             (bus.slave),
        .i_flags_clr     (flags_clr),
        .o_flags_q       (flags_q),
        .o_div_zero_trap (trap),
        .o_wb_count      (wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [3:0] op, input logic [3:0] rd, input logic [15:0] data, input logic [4:0] fl);
        bus.in_valid  = 1'b1;
        bus.in_opcode = op;
        bus.in_rd     = rd;
        bus.in_data   = data;
        bus.in_rflags = fl;
    endtask

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.in_opcode = 4'd0;
        bus.in_rd     = 4'd0;
        bus.in_data   = 16'd0;
        bus.in_rflags = 5'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flags_clr = 1'b0; bus.wb_ready = 1'b0; idle();
        repeat (2) @(negedge clk);
        checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got %b want 0", bus.wb_valid); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
        checks++; if (flags_q !== 5'd0) begin errors++; $display("FAIL reset_flags got %b want 00000", flags_q); end
        checks++; if (trap !== 1'b0) begin errors++; $display("FAIL reset_trap got %b want 0", trap); end
        checks++; if (wb_count !== 16'd0) begin errors++; $display("FAIL reset_wb_count got %0d want 0", wb_count); end
        checks++; if (bus.wb_rd !== 4'd0 || bus.wb_data !== 16'd0) begin errors++; $display("FAIL reset_head got rd=%0d data=%h want 0/0000", bus.wb_rd, bus.wb_data); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b want 1", bus.in_ready); end
        exp_count = 0;
    endtask

    task automatic test_add();
        bus.wb_ready = 1'b1;
        drive(OP_ADD, 4'd3, 16'h0005, 5'd0);
        @(negedge clk);
        idle();
        checks++; if (bus.wb_valid !== 1'b1) begin errors++; $display("FAIL add_wb_valid got %b want 1", bus.wb_valid); end
        checks++; if (bus.wb_rd !== 4'd3 || bus.wb_data !== 16'h0005) begin errors++; $display("FAIL add_head got rd=%0d data=%h want 3/0005", bus.wb_rd, bus.wb_data); end
        checks++; if (wb_count !== 16'd0) begin errors++; $display("FAIL add_count_before got %0d want 0", wb_count); end
        @(negedge clk);
        exp_count = 1;
        checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL add_drained got %b want 0", bus.wb_valid); end
        checks++; if (wb_count !== 16'(exp_count)) begin errors++; $display("FAIL add_count_after got %0d want %0d", wb_count, exp_count); end
    endtask

    task automatic test_cmp();
        drive(OP_CMP, 4'd5, 16'h0000, 5'b00100);
        @(negedge clk);
        idle();
        checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL cmp_no_write got %b want 0", bus.wb_valid); end
        checks++; if (flags_q !== 5'b00100) begin errors++; $display("FAIL cmp_flags got %b want 00100", flags_q); end
        @(negedge clk);
        checks++; if (wb_count !== 16'(exp_count)) begin errors++; $display("FAIL cmp_count got %0d want %0d", wb_count, exp_count); end
    endtask

    task automatic test_div();
        drive(OP_DIV, 4'd6, 16'hFFFF, 5'b00001);
        @(negedge clk);
        idle();
        checks++; if (trap !== 1'b1) begin errors++; $display("FAIL dz_trap_high got %b want 1", trap); end
        checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL dz_no_write got %b want 0", bus.wb_valid); end
        checks++; if (flags_q !== 5'b00001) begin errors++; $display("FAIL dz_flags got %b want 00001", flags_q); end
        @(negedge clk);
        checks++; if (trap !== 1'b0) begin errors++; $display("FAIL dz_trap_one_cycle got %b want 0", trap); end
        drive(OP_DIV, 4'd7, 16'h0009, 5'b00010);
        @(negedge clk);
        idle();
        checks++; if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 4'd7 || bus.wb_data !== 16'h0009) begin errors++; $display("FAIL div_ok_write got v=%b rd=%0d data=%h want 1/7/0009", bus.wb_valid, bus.wb_rd, bus.wb_data); end
        checks++; if (trap !== 1'b0 || flags_q !== 5'b00010) begin errors++; $display("FAIL div_ok_flags got trap=%b flags=%b want 0/00010", trap, flags_q); end
        @(negedge clk);
        exp_count = 2;
        checks++; if (wb_count !== 16'(exp_count)) begin errors++; $display("FAIL div_ok_count got %0d want %0d", wb_count, exp_count); end
        drive(OP_BAD, 4'd8, 16'h1234, 5'b01000);
        @(negedge clk);
        idle();
        checks++; if (bus.wb_valid !== 1'b0 || flags_q !== 5'b00010) begin errors++; $display("FAIL bad_op_dropped got v=%b flags=%b want 0/00010", bus.wb_valid, flags_q); end
    endtask

    task automatic test_back_to_back();
        bus.wb_ready = 1'b0;
        drive(OP_ADD, 4'd1, 16'h0011, 5'd0);
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_one got %b want 1", bus.in_ready); end
        drive(OP_ADD, 4'd2, 16'h0022, 5'd0);
        @(negedge clk);
        drive(OP_ADD, 4'd3, 16'h0033, 5'd0);
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready got %b want 0", bus.in_ready); end
        checks++; if (bus.wb_rd !== 4'd1 || bus.wb_data !== 16'h0011) begin errors++; $display("FAIL b2b_head1 got rd=%0d data=%h want 1/0011", bus.wb_rd, bus.wb_data); end
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b0 || bus.wb_rd !== 4'd1 || bus.wb_data !== 16'h0011) begin errors++; $display("FAIL b2b_stall_stable got rdy=%b rd=%0d data=%h want 0/1/0011", bus.in_ready, bus.wb_rd, bus.wb_data); end
        bus.wb_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.wb_rd !== 4'd2 || bus.wb_data !== 16'h0022) begin errors++; $display("FAIL b2b_head2 got rd=%0d data=%h want 2/0022", bus.wb_rd, bus.wb_data); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_slot_freed got %b want 1", bus.in_ready); end
        @(negedge clk);
        idle();
        checks++; if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 4'd3 || bus.wb_data !== 16'h0033) begin errors++; $display("FAIL b2b_head3 got v=%b rd=%0d data=%h want 1/3/0033", bus.wb_valid, bus.wb_rd, bus.wb_data); end
        @(negedge clk);
        exp_count = 5;
        checks++; if (bus.wb_valid !== 1'b0 || wb_count !== 16'(exp_count)) begin errors++; $display("FAIL b2b_drain got v=%b count=%0d want 0/%0d", bus.wb_valid, wb_count, exp_count); end
    endtask

    task automatic test_flags_clr();
        logic [4:0] exp_sticky;
        drive(OP_SUB, 4'd4, 16'h0001, 5'b10000);
        @(negedge clk);
        idle();
        checks++; if (flags_q !== 5'b10000) begin errors++; $display("FAIL clr_setup got %b want 10000", flags_q); end
        drive(OP_SUB, 4'd4, 16'h0002, 5'b00000);
        flags_clr = 1'b1;
        @(negedge clk);
        idle();
        flags_clr = 1'b0;
        checks++; if (flags_q !== 5'b00000) begin errors++; $display("FAIL clr_with_accept got %b want 00000", flags_q); end
        drive(OP_SUB, 4'd4, 16'h0003, 5'b10000);
        @(negedge clk);
        drive(OP_SUB, 4'd4, 16'h0004, 5'b00010);
        @(negedge clk);
        idle();
`ifdef ULA_WB_STICKY_OVF_EN
        exp_sticky = 5'b10010;
`else
        exp_sticky = 5'b00010;
`endif
        checks++; if (flags_q !== exp_sticky) begin errors++; $display("FAIL ovf_sticky got %b want %b", flags_q, exp_sticky); end
        flags_clr = 1'b1;
        @(negedge clk);
        flags_clr = 1'b0;
        checks++; if (flags_q !== 5'b00000) begin errors++; $display("FAIL clr_alone got %b want 00000", flags_q); end
        @(negedge clk);
        exp_count = 9;
        checks++; if (wb_count !== 16'(exp_count)) begin errors++; $display("FAIL clr_count got %0d want %0d", wb_count, exp_count); end
    endtask

    task automatic test_reset_mid();
        bus.wb_ready = 1'b0;
        drive(OP_ADD, 4'd9, 16'h0099, 5'b01000);
        @(negedge clk);
        drive(OP_ADD, 4'd10, 16'h00AA, 5'b01000);
        @(negedge clk);
        idle();
        checks++; if (bus.in_ready !== 1'b0 || bus.wb_valid !== 1'b1) begin errors++; $display("FAIL mid_full got rdy=%b v=%b want 0/1", bus.in_ready, bus.wb_valid); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.wb_valid !== 1'b0 || wb_count !== 16'd0 || flags_q !== 5'd0) begin errors++; $display("FAIL mid_reset got v=%b count=%0d flags=%b want 0/0/00000", bus.wb_valid, wb_count, flags_q); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_ready got %b want 0", bus.in_ready); end
        rst = 1'b0;
        bus.wb_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (bus.wb_valid !== 1'b0 || wb_count !== 16'd0) begin errors++; $display("FAIL mid_no_write cyc=%0d got v=%b count=%0d want 0/0", i, bus.wb_valid, wb_count); end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_count = 0;
        test_reset();
        test_add();
        test_cmp();
        test_div();
        test_back_to_back();
        test_flags_clr();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
